// File: rtl/adaptive_seq_ctrl_if.sv
// Handshake/status bundle between the adaptive-thresholding sequencer and its environment.
// master: the side that drives start/finished flags; slave: the sequencer itself.
interface adaptive_seq_ctrl_if #(
    parameter int unsigned TIMEOUT_BITS = 20
);
    logic                    iStart;
    logic                    iMeanFinished;
    logic                    iThreshFinished;
    logic [2:0]              oGlobalState;
    logic                    oStageResetN;
    logic                    oBusy;
    logic                    oDone;
    logic                    oError;
    logic [TIMEOUT_BITS-1:0] oMeanCycles;
    logic [TIMEOUT_BITS-1:0] oThreshCycles;

    modport master (
        output iStart, iMeanFinished, iThreshFinished,
        input  oGlobalState, oStageResetN, oBusy, oDone, oError,
        input  oMeanCycles, oThreshCycles
    );

    modport slave (
        input  iStart, iMeanFinished, iThreshFinished,
        output oGlobalState, oStageResetN, oBusy, oDone, oError,
        output oMeanCycles, oThreshCycles
    );
endinterface

// File: rtl/adaptive_seq_ctrl.sv
// Top-level sequencer for the adaptive-thresholding pipeline: CLEAR (stage reset),
// MEAN (threshold map), THRESH (binarisation + drain), then DONE or ERROR on watchdog expiry.
// Optional per-stage cycle counters are built only when ADAPTIVE_SEQ_PERF_EN is defined.
module adaptive_seq_ctrl #(
    parameter int unsigned RST_CYCLES   = 4,
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic                 clock,
    input  logic                 not_reset,
    adaptive_seq_ctrl_if.slave   bus
);

    localparam int unsigned CNT_MAX = (RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MEAN   = 3'd1,
        ST_THRESH = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERROR  = 3'd4,
        ST_CLEAR  = 3'd5
    } state_e;

    state_e                  state_q, state_d;
    logic                    start_q, start_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    drain_q, drain_d;
    logic [TIMEOUT_BITS-1:0] wd_q, wd_d;
    logic                    rstn_q, rstn_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic                    start_edge;
    logic                    wd_max;

    // Next-state, counters and registered-output values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        drain_d    = drain_q;
        wd_d       = wd_q;
        start_d    = bus.iStart;
        start_edge = bus.iStart & ~start_q;
        wd_max     = (wd_q == '1);

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_edge) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (cnt_q == CNT_W'(RST_CYCLES - 1)) state_d = ST_MEAN;
                else                                 cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_MEAN: begin
                if (bus.iMeanFinished) state_d = ST_THRESH;
                else if (wd_max)       state_d = ST_ERROR;
                else                   wd_d    = wd_q + TIMEOUT_BITS'(1);
            end
            ST_THRESH: begin
                // Watchdog stays frozen once draining; cnt_q is still 0 when drain starts.
                if (drain_q) begin
                    if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) state_d = ST_DONE;
                    else                                   cnt_d   = cnt_q + CNT_W'(1);
                end else if (bus.iThreshFinished) begin
                    if (DRAIN_CYCLES == 0) state_d = ST_DONE;
                    else                   drain_d = 1'b1;
                end else if (wd_max) begin
                    state_d = ST_ERROR;
                end else begin
                    wd_d = wd_q + TIMEOUT_BITS'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q) begin
            wd_d    = '0;
            cnt_d   = '0;
            drain_d = 1'b0;
        end

        rstn_d  = (state_d != ST_CLEAR);
        busy_d  = (state_d == ST_CLEAR) || (state_d == ST_MEAN) || (state_d == ST_THRESH);
        done_d  = (state_d == ST_DONE);
        error_d = (state_d == ST_ERROR);
    end

    // State, counters and output registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
            cnt_q   <= '0;
            drain_q <= 1'b0;
            wd_q    <= '0;
            rstn_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            wd_q    <= wd_d;
            rstn_q  <= rstn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign bus.oGlobalState = state_q;
    assign bus.oStageResetN = rstn_q;
    assign bus.oBusy        = busy_q;
    assign bus.oDone        = done_q;
    assign bus.oError       = error_q;

`ifdef ADAPTIVE_SEQ_PERF_EN
    localparam int unsigned SUM_W = TIMEOUT_BITS + 33;

    logic [TIMEOUT_BITS-1:0] mean_cyc_q, mean_cyc_d;
    logic [TIMEOUT_BITS-1:0] thr_cyc_q, thr_cyc_d;
    logic [SUM_W-1:0]        mean_sum, thr_sum;

    // Latch per-stage cycle counts on stage exit, saturating at all-ones.
    always_comb begin
        mean_cyc_d = mean_cyc_q;
        thr_cyc_d  = thr_cyc_q;
        mean_sum   = SUM_W'(wd_q) + SUM_W'(1);
        thr_sum    = SUM_W'(wd_q) + SUM_W'(1) + SUM_W'(DRAIN_CYCLES);
        if (state_q == ST_MEAN && state_d == ST_THRESH)
            mean_cyc_d = (|mean_sum[SUM_W-1:TIMEOUT_BITS]) ? '1 : mean_sum[TIMEOUT_BITS-1:0];
        if (state_q == ST_THRESH && state_d == ST_DONE)
            thr_cyc_d = (|thr_sum[SUM_W-1:TIMEOUT_BITS]) ? '1 : thr_sum[TIMEOUT_BITS-1:0];
        if (state_q == ST_MEAN && state_d == ST_ERROR)
            mean_cyc_d = '1;
        if (state_q == ST_THRESH && state_d == ST_ERROR)
            thr_cyc_d = '1;
    end

    // Perf registers.
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            mean_cyc_q <= '0;
            thr_cyc_q  <= '0;
        end else begin
            mean_cyc_q <= mean_cyc_d;
            thr_cyc_q  <= thr_cyc_d;
        end
    end

    assign bus.oMeanCycles   = mean_cyc_q;
    assign bus.oThreshCycles = thr_cyc_q;
`else
    assign bus.oMeanCycles   = '0;
    assign bus.oThreshCycles = '0;
`endif

endmodule
